// File: rtl/seg7_scan_if.sv
// Display-side bundle of the seg7_scan block: BCD capture inputs and scan outputs.
// The producer of BCD uses the master modport; the scanner uses the slave modport.
interface seg7_scan_if;
    logic [31:0] BCD;
    logic        bcd_valid;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_done;

    modport master (
        output BCD,
        output bcd_valid,
        input  AN,
        input  SEGMENT,
        input  frame_done
    );

    modport slave (
        input  BCD,
        input  bcd_valid,
        output AN,
        output SEGMENT,
        output frame_done
    );
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment scanner with frame-synchronous BCD update.
// Latency: AN/SEGMENT change the clk after each tick; new BCD shows from the next frame.
// Backpressure: none, captures always accepted; SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan #(
    parameter int SCAN_DIV = 17
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);

    localparam logic [SCAN_DIV-1:0] PRESC_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

    logic [SCAN_DIV-1:0] presc_q, presc_d;
    logic [2:0]          idx_q, idx_d;
    logic [31:0]         pend_q, pend_d;
    logic [31:0]         disp_q, disp_d;
    logic [7:0]          an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic                wrap;
    logic [3:0]          nib;
    logic                blank;

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    assign tick = (presc_q == '1);
    assign wrap = tick && (idx_q == 3'd7);
    assign nib  = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [2:0] msd;

    // Highest non-zero digit; invalid nibbles count as non-zero, digit 0 always shown.
    always_comb begin
        msd = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (disp_q[4*k +: 4] != 4'd0) begin
                msd = 3'(k);
            end
        end
        blank = (idx_q > msd);
    end
`else
    assign blank = 1'b0;
`endif

    // Outputs load the digit under the pre-increment index, so the first tick
    // after reset lights digit 0 and digit 7 still uses the outgoing display value.
    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        idx_d   = idx_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        an_d    = an_q;
        seg_d   = seg_q;
        frame_d = wrap;

        if (bus.bcd_valid) begin
            pend_d = bus.BCD;
        end
        if (tick) begin
            idx_d = idx_q + 3'd1;
            an_d  = ~(8'd1 << idx_q);
            seg_d = blank ? 8'hFF : seg_decode(nib);
        end
        if (wrap) begin
            disp_d = pend_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            pend_q  <= 32'd0;
            disp_q  <= 32'd0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.SEGMENT    = seg_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan at SCAN_DIV=2 (one digit every 4 clk, one frame every 32 clk).
module tb_seg7_scan;

    logic clk;
    logic rst;

    seg7_scan_if bus ();

    seg7_scan #(.SCAN_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_seg(input logic [31:0] v, input int k);
        logic [7:0] dec [16];
        int         msd;
        dec = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        msd = 0;
        for (int j = 1; j < 8; j++) begin
            if (v[4*j +: 4] != 4'd0) msd = j;
        end
        if (BLANK_EN && k > msd) return 8'hFF;
        return dec[v[4*k +: 4]];
    endfunction

    function automatic logic [7:0] an_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << k);
    endfunction

    task automatic capture(input logic [31:0] v);
        bus.BCD       = v;
        bus.bcd_valid = 1'b1;
        step(1);
        bus.bcd_valid = 1'b0;
    endtask

    // Leaves the bench just after the wrap edge (frame_done high, AN=7F).
    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step(1);
            if (bus.frame_done) seen = 1'b1;
        end
        if (!seen) chk("wait_frame_timeout", 32'd0, 32'd1);
    endtask

    // From a wrap edge, walks digits 0..7 and ends on the next wrap edge.
    task automatic check_frame(input string tag, input logic [31:0] v);
        for (int k = 0; k < 8; k++) begin
            step(4);
            chk({tag, "_an"},  32'(bus.AN),      32'(an_of(k)));
            chk({tag, "_seg"}, 32'(bus.SEGMENT), 32'(model_seg(v, k)));
        end
        chk({tag, "_fd"}, 32'(bus.frame_done), 32'd1);
    endtask

    initial begin
        logic [7:0] exp26 [8];
        int         hits;
        exp26 = '{8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        n_chk  = 0;
        n_pass = 0;
        rst           = 1'b1;
        bus.BCD       = 32'd0;
        bus.bcd_valid = 1'b0;

        step(3);
        chk("rst_an",  32'(bus.AN),         32'hFF);
        chk("rst_seg", 32'(bus.SEGMENT),    32'hFF);
        chk("rst_fd",  32'(bus.frame_done), 32'd0);

        rst = 1'b0;
        step(3);
        chk("pre_tick_an", 32'(bus.AN), 32'hFF);
        step(1);
        chk("first_tick_an",  32'(bus.AN),      32'hFE);
        chk("first_tick_seg", 32'(bus.SEGMENT), 32'hC0);

        // Full-digit walk
        capture(32'h98765432);
        wait_frame();
        chk("old_d7_an",  32'(bus.AN),      32'h7F);
        chk("old_d7_seg", 32'(bus.SEGMENT), 32'(model_seg(32'd0, 7)));
        for (int k = 0; k < 8; k++) begin
            step(4);
            chk("walk_an",  32'(bus.AN),      32'(an_of(k)));
            chk("walk_seg", 32'(bus.SEGMENT), 32'(exp26[k]));
        end
        chk("walk_fd", 32'(bus.frame_done), 32'd1);

        // Mid-frame capture must not disturb the running frame
        step(8);
        capture(32'h00000012);
        step(3);
        chk("mid_d2_an",  32'(bus.AN),      32'hFB);
        chk("mid_d2_seg", 32'(bus.SEGMENT), 32'h99);
        wait_frame();
        check_frame("bcd12", 32'h00000012);

        // Invalid nibble renders a dash
        step(8);
        capture(32'h0000000A);
        wait_frame();
        check_frame("bcdA", 32'h0000000A);

        // Second capture coincides with the wrap edge
        capture(32'h11111111);
        step(30);
        bus.BCD       = 32'h00000005;
        bus.bcd_valid = 1'b1;
        step(1);
        bus.bcd_valid = 1'b0;
        chk("wrap_cap_fd", 32'(bus.frame_done), 32'd1);
        check_frame("last_wins_1", 32'h11111111);
        check_frame("last_wins_5", 32'h00000005);

        // frame_done period and width over three frames
        hits = 0;
        for (int i = 1; i <= 96; i++) begin
            step(1);
            if (bus.frame_done) begin
                hits++;
                chk("fd_period", 32'(i), 32'(32 * hits));
            end
        end
        chk("fd_count", 32'(hits), 32'd3);

        // Asynchronous reset while frame_done is high; captures ignored during reset
        rst = 1'b1;
        #1;
        chk("async_rst_an",  32'(bus.AN),         32'hFF);
        chk("async_rst_seg", 32'(bus.SEGMENT),    32'hFF);
        chk("async_rst_fd",  32'(bus.frame_done), 32'd0);
        bus.BCD       = 32'h33333333;
        bus.bcd_valid = 1'b1;
        step(2);
        bus.bcd_valid = 1'b0;
        rst = 1'b0;
        step(3);
        chk("rerst_pre_an", 32'(bus.AN), 32'hFF);
        step(1);
        chk("rerst_tick_an",  32'(bus.AN),      32'hFE);
        chk("rerst_tick_seg", 32'(bus.SEGMENT), 32'hC0);
        wait_frame();
        check_frame("rst_ignored_cap", 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
